ef_pwm32_apb: RTL and testbench



---
 rtl/ef_pwm32_apb_pkg.sv | 20 ++
 rtl/pwm32_core.sv | 90 +++++++++
 rtl/ef_pwm32_apb.sv | 99 +++++++++
 tb/tb_ef_pwm32_apb.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ef_pwm32_apb_pkg.sv
// rtl/ef_pwm32_apb_pkg.sv - register offsets and CTRL bit indices for ef_pwm32_apb
package ef_pwm32_apb_pkg;

    // Word indices decoded from PADDR[4:2]
    localparam logic [2:0] REG_PERIOD   = 3'd0;
    localparam logic [2:0] REG_CMPA     = 3'd1;
    localparam logic [2:0] REG_CMPB     = 3'd2;
    localparam logic [2:0] REG_CTRL     = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_COUNT    = 3'd5;

    // CTRL bit positions
    localparam int CTRL_EN    = 0;
    localparam int CTRL_A_EN  = 1;
    localparam int CTRL_B_EN  = 2;
    localparam int CTRL_INV_A = 3;
    localparam int CTRL_INV_B = 4;
    localparam int CTRL_W     = 5;

endpackage

// File: rtl/pwm32_core.sv
// rtl/pwm32_core.sv - prescaler, 32-bit period counter, shadowed compares, two PWM outputs
// Ports: clk/rst_n (async active-low); en, a_en, b_en, inv_a, inv_b control bits;
//        period_sw, cmpa_sw, cmpb_sw software values; prescale divider;
//        count live counter; pwm_a, pwm_b registered outputs.
module pwm32_core
    import ef_pwm32_apb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        a_en,
    input  logic        b_en,
    input  logic        inv_a,
    input  logic        inv_b,
    input  logic [31:0] period_sw,
    input  logic [31:0] cmpa_sw,
    input  logic [31:0] cmpb_sw,
    input  logic [15:0] prescale,
    output logic [31:0] count,
    output logic        pwm_a,
    output logic        pwm_b
);

    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic [31:0] count_q, count_d;
    logic [31:0] period_act_q, period_act_d;
    logic [31:0] cmpa_act_q, cmpa_act_d;
    logic [31:0] cmpb_act_q, cmpb_act_d;
    logic        pwm_a_q, pwm_a_d;
    logic        pwm_b_q, pwm_b_d;
    logic        tick;
    logic        wrap;

    assign tick = en && (pre_cnt_q == prescale);
    // Wrap is an equality test, so PERIOD=0xFFFFFFFF never overflows count
    assign wrap = tick && (count_q == period_act_q);

    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        count_d      = count_q;
        period_act_d = period_act_q;
        cmpa_act_d   = cmpa_act_q;
        cmpb_act_d   = cmpb_act_q;
        if (!en) begin
            // Stopped: counters parked, active copies track software values
            pre_cnt_d    = 16'd0;
            count_d      = 32'd0;
            period_act_d = period_sw;
            cmpa_act_d   = cmpa_sw;
            cmpb_act_d   = cmpb_sw;
        end else begin
            pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
            if (wrap) begin
                count_d      = 32'd0;
                period_act_d = period_sw;
                cmpa_act_d   = cmpa_sw;
                cmpb_act_d   = cmpb_sw;
            end else if (tick) begin
                count_d = count_q + 32'd1;
            end
        end
        pwm_a_d = (en && a_en) ? ((count_q < cmpa_act_q) ^ inv_a) : 1'b0;
        pwm_b_d = (en && b_en) ? ((count_q < cmpb_act_q) ^ inv_b) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q    <= 16'd0;
            count_q      <= 32'd0;
            period_act_q <= 32'd0;
            cmpa_act_q   <= 32'd0;
            cmpb_act_q   <= 32'd0;
            pwm_a_q      <= 1'b0;
            pwm_b_q      <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            count_q      <= count_d;
            period_act_q <= period_act_d;
            cmpa_act_q   <= cmpa_act_d;
            cmpb_act_q   <= cmpb_act_d;
            pwm_a_q      <= pwm_a_d;
            pwm_b_q      <= pwm_b_d;
        end
    end

    assign count = count_q;
    assign pwm_a = pwm_a_q;
    assign pwm_b = pwm_b_q;

endmodule

// File: rtl/ef_pwm32_apb.sv
// rtl/ef_pwm32_apb.sv - APB register file wrapping the dual-channel 32-bit PWM core
// Ports: PCLK/PRESETn (async active-low); APB slave PADDR, PSEL, PENABLE, PWRITE,
//        PWDATA, PRDATA (combinational), PREADY (always 1); pwmA, pwmB outputs.
module ef_pwm32_apb
    import ef_pwm32_apb_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [31:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        pwmA,
    output logic        pwmB
);

    logic [31:0]       period_q, period_d;
    logic [31:0]       cmpa_q, cmpa_d;
    logic [31:0]       cmpb_q, cmpb_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       prescale_q, prescale_d;
    logic [31:0]       count;
    logic [2:0]        reg_idx;
    logic              wr_en;
    logic              unused_addr_bits;

    assign reg_idx          = PADDR[4:2];
    assign wr_en            = PSEL & PENABLE & PWRITE;
    assign unused_addr_bits = ^{PADDR[31:5], PADDR[1:0]};
    assign PREADY           = 1'b1;

    always_comb begin
        period_d   = period_q;
        cmpa_d     = cmpa_q;
        cmpb_d     = cmpb_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        if (wr_en) begin
            case (reg_idx)
                REG_PERIOD:   period_d   = PWDATA;
                REG_CMPA:     cmpa_d     = PWDATA;
                REG_CMPB:     cmpb_d     = PWDATA;
                REG_CTRL:     ctrl_d     = PWDATA[CTRL_W-1:0];
                REG_PRESCALE: prescale_d = PWDATA[15:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            period_q   <= 32'd0;
            cmpa_q     <= 32'd0;
            cmpb_q     <= 32'd0;
            ctrl_q     <= '0;
            prescale_q <= 16'd0;
        end else begin
            period_q   <= period_d;
            cmpa_q     <= cmpa_d;
            cmpb_q     <= cmpb_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
        end
    end

    always_comb begin
        PRDATA = 32'd0;
        case (reg_idx)
            REG_PERIOD:   PRDATA = period_q;
            REG_CMPA:     PRDATA = cmpa_q;
            REG_CMPB:     PRDATA = cmpb_q;
            REG_CTRL:     PRDATA = {{(32-CTRL_W){1'b0}}, ctrl_q};
            REG_PRESCALE: PRDATA = {16'd0, prescale_q};
            REG_COUNT:    PRDATA = count;
            default:      PRDATA = 32'd0;
        endcase
    end

    pwm32_core u_core (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .en        (ctrl_q[CTRL_EN]),
        .a_en      (ctrl_q[CTRL_A_EN]),
        .b_en      (ctrl_q[CTRL_B_EN]),
        .inv_a     (ctrl_q[CTRL_INV_A]),
        .inv_b     (ctrl_q[CTRL_INV_B]),
        .period_sw (period_q),
        .cmpa_sw   (cmpa_q),
        .cmpb_sw   (cmpb_q),
        .prescale  (prescale_q),
        .count     (count),
        .pwm_a     (pwmA),
        .pwm_b     (pwmB)
    );

endmodule

// File: tb/tb_ef_pwm32_apb.sv
// tb/tb_ef_pwm32_apb.sv - self-checking bench for ef_pwm32_apb
module tb_ef_pwm32_apb;

    logic        PCLK;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        pwmA;
    logic        pwmB;

    int vectors;
    int miscompares;

    ef_pwm32_apb dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .pwmA    (pwmA),
        .pwmB    (pwmB)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    localparam logic [31:0] A_PERIOD   = 32'h00;
    localparam logic [31:0] A_CMPA     = 32'h04;
    localparam logic [31:0] A_CMPB     = 32'h08;
    localparam logic [31:0] A_CTRL     = 32'h0C;
    localparam logic [31:0] A_PRESCALE = 32'h10;
    localparam logic [31:0] A_COUNT    = 32'h14;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ends #1 after the commit edge
    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        PADDR = addr; PWDATA = data; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge PCLK);
        PADDR = addr; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(posedge PCLK);
        #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // Counter value j clocks after the enabling edge, for a fixed configuration
    function automatic logic [31:0] model_count(input longint unsigned j, input logic [31:0] period,
                                                input logic [15:0] pre);
        longint unsigned per_len;
        per_len = longint'(period) + 64'd1;
        return 32'((j / (longint'(pre) + 64'd1)) % per_len);
    endfunction

    function automatic logic model_level(input logic [31:0] c, input logic [31:0] cmp,
                                         input logic en, input logic ch_en, input logic inv);
        return (en && ch_en) ? ((c < cmp) ^ inv) : 1'b0;
    endfunction

    // Program a configuration from a stopped state, enable, and compare for ncyc clocks
    task automatic run_check(input logic [31:0] period, input logic [31:0] cmpa,
                             input logic [31:0] cmpb, input logic [15:0] pre,
                             input logic [31:0] ctrl, input int ncyc,
                             output int hi_a, output int hi_b);
        logic [31:0] c_now, c_prev;
        logic        en;
        hi_a = 0; hi_b = 0;
        apb_write(A_CTRL, 32'd0);
        apb_write(A_PERIOD, period);
        apb_write(A_CMPA, cmpa);
        apb_write(A_CMPB, cmpb);
        apb_write(A_PRESCALE, {16'd0, pre});
        apb_write(A_CTRL, ctrl);
        PADDR = A_COUNT;
        en = ctrl[0];
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge PCLK);
            #1;
            c_now  = en ? model_count(longint'(k), period, pre) : 32'd0;
            c_prev = en ? model_count(longint'(k - 1), period, pre) : 32'd0;
            check("count", PRDATA, c_now);
            check("pwmA", {31'd0, pwmA}, {31'd0, model_level(c_prev, cmpa, en, ctrl[1], ctrl[3])});
            check("pwmB", {31'd0, pwmB}, {31'd0, model_level(c_prev, cmpb, en, ctrl[2], ctrl[4])});
            hi_a += int'(pwmA);
            hi_b += int'(pwmB);
        end
    endtask

    reg_vec_t    rv[$];
    logic [31:0] rd;
    int          ha, hb;
    logic [31:0] exp_c;

    initial begin
        vectors = 0; miscompares = 0;
        PADDR = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = 0;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pwmA", {31'd0, pwmA}, 32'd0);
        check("rst_pwmB", {31'd0, pwmB}, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            apb_read(32'(i * 4), rd);
            check("rst_reg", rd, 32'd0);
        end

        // Register access table: write then read back
        rv.push_back('{A_PERIOD,   32'hDEADBEEF, 32'hDEADBEEF});
        rv.push_back('{A_CMPA,     32'h12345678, 32'h12345678});
        rv.push_back('{A_CMPB,     32'hA5A5A5A5, 32'hA5A5A5A5});
        rv.push_back('{A_CTRL,     32'hFFFFFFE6, 32'h00000006});
        rv.push_back('{A_PRESCALE, 32'hABCD1234, 32'h00001234});
        rv.push_back('{A_COUNT,    32'h00000055, 32'h00000000});
        rv.push_back('{32'h18,     32'hFFFFFFFF, 32'h00000000});
        rv.push_back('{32'h1C,     32'hFFFFFFFF, 32'h00000000});
        rv.push_back('{32'h107,    32'h0BADF00D, 32'h0BADF00D});
        rv.push_back('{A_CTRL,     32'h00000018, 32'h00000018});
        foreach (rv[i]) begin
            apb_write(rv[i].addr, rv[i].wdata);
            apb_read(rv[i].addr, rd);
            check("regfile", rd, rv[i].exp);
        end

        // Basic PWM: A high 3 of every 10 clocks, B idle
        run_check(32'd9, 32'd3, 32'd5, 16'd0, 32'h3, 20, ha, hb);
        check("basic_hiA", 32'(ha), 32'd6);
        check("basic_hiB", 32'(hb), 32'd0);

        // Prescale + inversion on B: low 4, high 6 per 10 clocks
        run_check(32'd4, 32'd0, 32'd2, 16'd1, 32'h15, 20, ha, hb);
        check("pre_inv_hiB", 32'(hb), 32'd12);
        check("pre_inv_hiA", 32'(ha), 32'd0);

        // Extremes
        run_check(32'd7, 32'd0, 32'd8, 16'd0, 32'h7, 16, ha, hb);
        check("cmp0_hiA", 32'(ha), 32'd0);
        check("cmpmax_hiB", 32'(hb), 32'd16);
        run_check(32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 16'd2, 32'h7, 20, ha, hb);

        // Randomised configurations
        for (int it = 0; it < 10; it++) begin
            logic [31:0] p;
            p = 32'($urandom_range(0, 12));
            run_check(p, 32'($urandom_range(0, p + 2)), 32'($urandom_range(0, p + 2)),
                      16'($urandom_range(0, 3)), 32'($urandom_range(0, 31)), 40, ha, hb);
        end

        // Shadow: PERIOD=19 written at edge T+2 only applies after the first wrap
        apb_write(A_CTRL, 32'd0);
        apb_write(A_PERIOD, 32'd9);
        apb_write(A_CMPA, 32'd3);
        apb_write(A_PRESCALE, 32'd0);
        apb_write(A_CTRL, 32'h3);
        apb_write(A_PERIOD, 32'd19);
        PADDR = A_COUNT;
        for (int j = 3; j <= 45; j++) begin
            @(posedge PCLK);
            #1;
            exp_c = (j <= 9) ? 32'(j) : 32'((j - 10) % 20);
            check("shadow_count", PRDATA, exp_c);
        end

        // Disable mid-run with A held high
        run_check(32'd9, 32'd10, 32'd0, 16'd0, 32'h3, 6, ha, hb);
        check("const_hiA", 32'(ha), 32'd6);
        apb_write(A_CTRL, 32'd0);
        PADDR = A_COUNT;
        for (int j = 1; j <= 2; j++) begin
            @(posedge PCLK);
            #1;
            check("dis_count", PRDATA, 32'd0);
            check("dis_pwmA", {31'd0, pwmA}, 32'd0);
            check("dis_pwmB", {31'd0, pwmB}, 32'd0);
        end

        // Asynchronous reset while pwmA is high
        apb_write(A_CTRL, 32'h3);
        repeat (3) @(posedge PCLK);
        #1;
        check("pre_rst_pwmA", {31'd0, pwmA}, 32'd1);
        @(posedge PCLK);
        #3 PRESETn = 1'b0;
        #1;
        check("async_pwmA", {31'd0, pwmA}, 32'd0);
        check("async_pwmB", {31'd0, pwmB}, 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        apb_read(A_CTRL, rd);
        check("post_rst_ctrl", rd, 32'd0);
        apb_read(A_PERIOD, rd);
        check("post_rst_period", rd, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
